// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame length, cycle constants and parity helper
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE, ERR} ps2_tx_state_t;
  localparam int PS2_FRAME_EDGES = 11;
  localparam int PS2_FILTER_LEN = 19;
  localparam int PS2_INHIBIT_CYCLES = 10000;
  localparam int PS2_TIMEOUT_CYCLES = 2000000;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer plus glitch filter; output follows the line only after FILTER_LEN stable samples
module ps2_line_filter #(
  parameter int FILTER_LEN = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic filtered
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      cnt <= '0;
      filtered <= 1'b1;
    end else begin
      sync <= {sync[0], line};
      if (sync[1] == filtered) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        filtered <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command byte sender (inhibit, request-to-send, shift, acknowledge).
// Define PS2_TX_ACK_CHECK_EN to turn a missing device acknowledge into an error.
module ps2_transmitter import ps2_pkg::*; #(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  ps2_tx_state_t state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [3:0] n, n_n;
  logic [9:0] frame, frame_n;
  logic ack, ack_n, clk_oe_n, data_oe_n;
  logic clk_f, data_f, clk_d, fall, timeout;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (.clk(clk), .rst_n(rst_n), .line(ps2_clk_in), .filtered(clk_f));
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (.clk(clk), .rst_n(rst_n), .line(ps2_data_in), .filtered(data_f));
  assign fall = clk_d & ~clk_f;
  assign timeout = cnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      frame <= '0;
      ack <= 1'b0;
      clk_d <= 1'b1;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      n <= n_n;
      frame <= frame_n;
      ack <= ack_n;
      clk_d <= clk_f;
      ps2_clk_oe <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      error <= state_n == ERR;
    end
  end
  // frame holds {stop, parity, data}; bit n is driven after falling edge n+1
  always_comb begin
    state_n = state;
    cnt_n = cnt + 32'd1;
    n_n = n;
    frame_n = frame;
    ack_n = ack;
    clk_oe_n = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    case (state)
      IDLE: begin
        cnt_n = '0;
        clk_oe_n = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_n = {1'b1, odd_parity(tx_data), tx_data};
          n_n = '0;
          ack_n = 1'b0;
          clk_oe_n = 1'b1;
          state_n = INHIBIT;
        end
      end
      INHIBIT: if (cnt == 32'(INHIBIT_CYCLES - 1)) begin
        data_oe_n = 1'b1;
        state_n = REQ;
      end
      REQ: begin
        clk_oe_n = 1'b0;
        cnt_n = '0;
        state_n = SHIFT;
      end
      SHIFT: if (fall) begin
        cnt_n = '0;
        data_oe_n = ~frame[n];
        n_n = n + 4'd1;
        state_n = n == 4'(PS2_FRAME_EDGES - 2) ? ACK : SHIFT;
      end else if (timeout) begin
        data_oe_n = 1'b0;
        state_n = ERR;
      end
      ACK: if (fall) begin
        cnt_n = '0;
`ifdef PS2_TX_ACK_CHECK_EN
        ack_n = ~data_f;
`else
        ack_n = 1'b1;
`endif
        state_n = WAIT_IDLE;
      end else if (timeout) begin
        data_oe_n = 1'b0;
        state_n = ERR;
      end
      WAIT_IDLE: if (clk_f && data_f) state_n = ack ? DONE : ERR;
        else if (timeout) begin
          data_oe_n = 1'b0;
          state_n = ERR;
        end
      DONE, ERR: begin
        clk_oe_n = 1'b0;
        data_oe_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: directed device-model bench for ps2_transmitter (scaled cycle counts)
module tb_ps2_transmitter;
  localparam int INH = 100;
  localparam int TO = 3000;
  localparam int FL = 4;
  localparam int HALF = 40;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, busy, done, error, ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_in, ps2_data_in;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;
  ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .error(error), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic start(input logic [7:0] b);
    int c;
    tx_data = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("accept_clk_oe", 32'(ps2_clk_oe), 1);
    chk("accept_busy", 32'(busy), 1);
    c = 0;
    while (ps2_clk_oe && !ps2_data_oe && c < INH + 10) begin
      c++;
      tick();
    end
    chk("inhibit_len", c, INH);
    c = 0;
    while (ps2_clk_oe && ps2_data_oe && c < 10) begin
      c++;
      tick();
    end
    chk("req_len", c, 1);
    chk("start_bit_lines", 32'({ps2_clk_oe, ps2_data_oe}), 1);
  endtask
  task automatic device(input bit ack, input bit glitch, input int abort_edge, output logic [9:0] obs);
    obs = '0;
    tick(20);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) begin
        dev_data = !ack;
        tick(HALF / 2);
      end
      dev_clk = 1'b0;
      if (i == abort_edge) begin
        tick(FL + 6);
        chk("pre_reset_data_oe", 32'(ps2_data_oe), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_clk_oe", 32'(ps2_clk_oe), 0);
        chk("async_reset_data_oe", 32'(ps2_data_oe), 0);
        chk("async_reset_ready", 32'(tx_ready), 1);
        dev_clk = 1'b1;
        return;
      end
      tick(HALF);
      if (i <= 10) obs[i-1] = ps2_data_in;
      dev_clk = 1'b1;
      if (i == 11) dev_data = 1'b1;
      else if (glitch && i == 4) begin
        tx_data = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("busy_ignores_valid", 32'(tx_ready), 0);
        tick(HALF / 2);
        dev_clk = 1'b0;
        tick(2);
        dev_clk = 1'b1;
        tick(HALF / 2);
      end else tick(HALF);
    end
  endtask
  task automatic result(input bit exp_done, input string tag);
    int c;
    c = 0;
    while (!done && !error && c < 2000) begin
      c++;
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(!exp_done));
    tick();
    chk({tag, "_pulse_end"}, 32'({done, error}), 0);
    chk({tag, "_ready"}, 32'(tx_ready), 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [9:0] obs;
    int c;
    tick(2);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("rst_data_oe", 32'(ps2_data_oe), 0);
    rst_n = 1'b1;
    tick(FL + 5);
    start(8'hED); device(1'b1, 1'b0, 0, obs); chk("bits_ED", 32'(obs), 32'h3ED); result(1'b1, "ED");
    start(8'h00); device(1'b1, 1'b0, 0, obs); chk("bits_00", 32'(obs), 32'h300); result(1'b1, "x00");
    start(8'h01); device(1'b1, 1'b0, 0, obs); chk("bits_01", 32'(obs), 32'h201); result(1'b1, "x01");
    start(8'h55);
    c = 0;
    while (!error && c < TO + 100) begin
      c++;
      tick();
    end
    chk("timeout_len", c, TO);
    chk("timeout_clk_oe", 32'(ps2_clk_oe), 0);
    chk("timeout_data_oe", 32'(ps2_data_oe), 0);
    chk("timeout_ready_low", 32'(tx_ready), 0);
    tick();
    chk("timeout_ready", 32'(tx_ready), 1);
    chk("timeout_pulse_end", 32'(error), 0);
    start(8'hED); device(1'b0, 1'b0, 0, obs); chk("bits_nack", 32'(obs), 32'h3ED);
`ifdef PS2_TX_ACK_CHECK_EN
    result(1'b0, "nack");
`else
    result(1'b1, "nack");
`endif
    start(8'hA5); device(1'b1, 1'b1, 0, obs); chk("bits_A5_glitch", 32'(obs), 32'h3A5); result(1'b1, "A5");
    tick(20);
    chk("no_queued_frame", 32'(ps2_clk_oe), 0);
    start(8'h00); device(1'b1, 1'b0, 5, obs);
    tick();
    rst_n = 1'b1;
    tick(FL + 5);
    chk("post_reset_ready", 32'(tx_ready), 1);
    start(8'hFF); device(1'b1, 1'b0, 0, obs); chk("bits_FF", 32'(obs), 32'h3FF); result(1'b1, "FF");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_transmitter.md
# ps2_transmitter

Host-to-device PS/2 transmitter that sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, …) to the keyboard on the same open-drain clock/data pair the keyboard receiver listens on. It runs the host-request sequence: inhibit the clock, issue a request-to-send, shift the frame on device-generated clock edges, then check the device acknowledge. While it is busy, the keyboard receive path treats traffic on the lines as transmit activity, not as keycodes.

## Interface
Parameters:
- INHIBIT_CYCLES, 10000: clk cycles the host holds ps2_clk low before the request (100 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum clk cycles between consecutive device clock falling edges, and between request and the first edge (20 ms).
- FILTER_LEN, 19: stable-sample count required by the line filter before a filtered line changes.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- tx_data, in, 8: byte to send. Sampled on accept.
- tx_valid, in, 1: send request.
- tx_ready, out, 1: high in IDLE. A byte is accepted when tx_valid && tx_ready.
- busy, out, 1: high from accept through DONE/ERR.
- done, out, 1: one-cycle pulse on successful completion.
- error, out, 1: one-cycle pulse on timeout or missing acknowledge.
- ps2_clk_in, in, 1: raw PS/2 clock line.
- ps2_data_in, in, 1: raw PS/2 data line.
- ps2_clk_oe, out, 1: 1 = drive ps2_clk low; 0 = release.
- ps2_data_oe, out, 1: 1 = drive ps2_data low; 0 = release.

## Operation
- Both inputs pass through a 2-FF synchronizer and a FILTER_LEN glitch filter. A device clock falling edge is a 1→0 change of the filtered clock.
- Frame after the start bit:
  - 8 data bits, LSB first.
  - Odd parity bit.
  - Stop bit (data released).
  - Acknowledge from the device.
- State machine:
  - IDLE: lines released; tx_ready=1. On accept, latch tx_data, compute parity = ~^tx_data, clear counters, go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES, then ps2_data_oe=1 (start bit), go to REQ.
  - REQ: one cycle with both driven; then release clk (ps2_clk_oe=0), go to SHIFT.
  - SHIFT: keep data driving per bit. On each falling edge n=1..10, set ps2_data_oe = ~bit[n]:
    - n=1..8: data bits 0..7.
    - n=9: parity.
    - n=10: stop, data released.
    - Then go to ACK.
  - ACK: on the 11th falling edge, sample filtered data. Low means acknowledged. Go to WAIT_IDLE.
  - WAIT_IDLE: wait for filtered clk=1 and data=1, then go to DONE (acknowledged) or ERR (no acknowledge).
  - DONE / ERR: one cycle; pulse done or error; go to IDLE.
- Timeout:
  - The counter clears on every falling edge and on entry to SHIFT.
  - In SHIFT, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES goes to ERR and releases both lines immediately.
- tx_valid while busy is ignored. The byte is not queued.
- Reset mid-frame releases both lines on the asynchronous edge and returns to IDLE. Any partial frame is abandoned.

## Timing
- Reset values:
  - ps2_clk_oe=0, ps2_data_oe=0.
  - busy=0, done=0, error=0.
  - tx_ready=1 (IDLE).
- Accept edge to ps2_clk_oe=1: 1 cycle.
- ps2_clk_oe low time: exactly INHIBIT_CYCLES cycles, plus 1 REQ cycle with data also driven.
- Line change to filtered line change: 2 + FILTER_LEN cycles. ps2_data_oe updates 1 cycle after the detected edge, well inside the device clock-low half period (about 30 µs).
- done/error assert exactly 1 cycle. tx_ready rises the cycle after.
- All outputs are registered.

## Configuration
- PS2_TX_ACK_CHECK_EN defined: the acknowledge sample is honoured; data high at edge 11 ends in error.
- PS2_TX_ACK_CHECK_EN undefined: the acknowledge is not checked; every frame that reaches WAIT_IDLE ends in done. Timeouts still produce error.

## Structure
- Package ps2_pkg holds:
  - State enum.
  - PS2_FRAME_EDGES=11.
  - The odd-parity function.
  - Common cycle constants, shared with the receiver.
- One sub-module, ps2_line_filter (synchronizer plus glitch filter), instantiated for clk and data.

## Test plan
- Device model (clock period 80 µs, acknowledge low), send 0xED: observed bits 1,0,1,1,0,1,1,1, parity 1, stop 1, then done pulse; clk held low ≥10000 cycles.
- Send 0x00: data bits all 0, parity 1. Send 0x01: parity 0. Both end in done.
- Device never clocks after the request: error exactly TIMEOUT_CYCLES after clk release; both oe=0; tx_ready=1.
- Device leaves data high at edge 11: error with PS2_TX_ACK_CHECK_EN defined; done without it.
- rst_n asserted at edge 5 of a frame: oe outputs go 0 asynchronously; after release, tx_ready=1 and a new 0xFF send completes.
- 2-cycle glitches on ps2_clk_in in mid-frame: ignored, frame bits unchanged; tx_valid pulses while busy are not accepted.
